// File: rtl/fifo_pack_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pack_pkg
// Shared definitions for the FIFO pack reader:
//   - state_e   : reader FSM states (filling / draining a partial word)
//   - CNT_W     : lane-counter width for the default 4-lane configuration
//   - keep_mask : builds a lane-valid mask with the low n bits set
// -----------------------------------------------------------------------------
package fifo_pack_pkg;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    localparam int RATIO_DEFAULT = 4;
    localparam int CNT_W         = $clog2(RATIO_DEFAULT + 1);

    // Widest keep mask the helper can produce; callers cast down to RATIO bits.
    localparam int KEEP_MAX = 32;

    // Mask with bits [n-1:0] set, i.e. (1 << n) - 1 without overflow at n == KEEP_MAX.
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
        logic [KEEP_MAX-1:0] m;
        m = {KEEP_MAX{1'b0}};
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_pack_reader_out.sv
// -----------------------------------------------------------------------------
// pack_out_reg
// Single-entry valid/ready holding register for the packed output word.
// The parent only asserts i_load when the register is free (empty or being
// accepted this cycle), so a load never overwrites an unaccepted word.
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_load                 : capture i_data/i_keep/i_last and raise o_valid
//   i_data, i_keep, i_last : word to capture
//   i_ready                : downstream accepts when o_valid && i_ready
//   o_valid, o_data,
//   o_keep, o_last         : registered stream outputs, stable while stalled
// -----------------------------------------------------------------------------
module pack_out_reg
    import fifo_pack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last
);

    // Holding register: load wins over accept so back-to-back words never bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= {DATA_W{1'b0}};
            o_keep  <= {KEEP_W{1'b0}};
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_keep  <= i_keep;
            o_last  <= i_last;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// fifo_pack_reader
// Reads WIDTH-bit entries from a synchronous FIFO (registered read data, one
// cycle latency) and packs RATIO consecutive entries into one output word,
// lane 0 = oldest entry. A flush request emits a partial word with a keep mask
// and O_LAST set so the tail of a message is never stranded.
//   I_CLK, I_RESET : clock, synchronous active-high reset
//   I_EMPTY, O_RE  : FIFO empty flag / read enable
//   I_DIN          : FIFO read data, valid the cycle after an accepted read
//   I_FLUSH        : single-cycle request to emit the current partial word
//   O_DATA, O_KEEP, O_LAST, O_VALID, I_READY : packed output stream
//   O_BUSY         : flush in progress
// -----------------------------------------------------------------------------
module fifo_pack_reader
    import fifo_pack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic                   I_EMPTY,
    output logic                   O_RE,
    input  logic [WIDTH-1:0]       I_DIN,
    input  logic                   I_FLUSH,
    output logic [WIDTH*RATIO-1:0] O_DATA,
    output logic [RATIO-1:0]       O_KEEP,
    output logic                   O_LAST,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic                   O_BUSY
);

    localparam int CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);
    localparam logic [CW:0]   RATIO_X  = (CW + 1)'(RATIO);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic                   r_pend;
    logic [WIDTH*RATIO-1:0] r_acc;

    logic                   w_re;
    logic [CW:0]            w_inflight;
    logic                   w_out_valid;
    logic                   w_free;
    logic                   w_xfer_full;
    logic                   w_xfer_part;
    logic                   w_xfer;
    logic [RATIO-1:0]       w_lane_keep;
    logic [WIDTH*RATIO-1:0] w_load_data;
    logic [RATIO-1:0]       w_load_keep;
    logic                   w_load_last;

    // Lanes filled plus the one still in flight; reads stop once this reaches
    // RATIO so the accumulator can never be overrun while the output stalls.
    assign w_inflight = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
    assign w_re       = !I_RESET && !I_EMPTY && (r_state == S_FILL) && (w_inflight < RATIO_X);
    assign O_RE       = w_re;

    assign w_free      = !w_out_valid || I_READY;
    assign w_xfer_full = w_free && (r_cnt == FULL_CNT);
    // A full accumulator during a flush leaves as a normal word (O_LAST = 0);
    // the flush then completes through the empty-accumulator exit.
    assign w_xfer_part = w_free && (r_state == S_FLUSH) && !r_pend &&
                         (r_cnt != {CW{1'b0}}) && (r_cnt != FULL_CNT);
    assign w_xfer      = w_xfer_full || w_xfer_part;
    assign w_lane_keep = RATIO'(keep_mask(32'(r_cnt)));

    // Word presented to the holding register; unfilled lanes of a partial word are zeroed.
    always_comb begin
        w_load_data = {(WIDTH*RATIO){1'b0}};
        w_load_keep = {RATIO{1'b0}};
        w_load_last = 1'b0;
        if (w_xfer_full) begin
            w_load_data = r_acc;
            w_load_keep = {RATIO{1'b1}};
            w_load_last = 1'b0;
        end else if (w_xfer_part) begin
            for (int k = 0; k < RATIO; k++) begin
                if (w_lane_keep[k]) begin
                    w_load_data[k*WIDTH +: WIDTH] = r_acc[k*WIDTH +: WIDTH];
                end else begin
                    w_load_data[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                end
            end
            w_load_keep = w_lane_keep;
            w_load_last = 1'b1;
        end else begin
            w_load_data = {(WIDTH*RATIO){1'b0}};
            w_load_keep = {RATIO{1'b0}};
            w_load_last = 1'b0;
        end
    end

    // Next-state logic: a flush waits for any in-flight entry before deciding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (I_FLUSH) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FLUSH: begin
                if (w_xfer_part || (!r_pend && (r_cnt == {CW{1'b0}}))) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_FLUSH;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // State, read-pending flag, lane counter and accumulator; a transfer and a
    // capture never coincide because both transfer types require !r_pend.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_state <= S_FILL;
            r_pend  <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_acc   <= {(WIDTH*RATIO){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_re;
            if (w_xfer) begin
                r_cnt <= {CW{1'b0}};
            end else if (r_pend) begin
                r_cnt                              <= r_cnt + CW'(1);
                r_acc[int'(r_cnt)*WIDTH +: WIDTH] <= I_DIN;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign O_BUSY = (r_state == S_FLUSH);

    pack_out_reg #(
        .DATA_W (WIDTH * RATIO),
        .KEEP_W (RATIO)
    ) u_out (
        .i_clk   (I_CLK),
        .i_reset (I_RESET),
        .i_load  (w_xfer),
        .i_data  (w_load_data),
        .i_keep  (w_load_keep),
        .i_last  (w_load_last),
        .i_ready (I_READY),
        .o_valid (w_out_valid),
        .o_data  (O_DATA),
        .o_keep  (O_KEEP),
        .o_last  (O_LAST)
    );

    assign O_VALID = w_out_valid;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_pack_reader
// Bench for fifo_pack_reader (WIDTH=8, RATIO=4) with a behavioural FIFO that
// has registered read data. Expected words go to a scoreboard queue when the
// stimulus is driven and are compared when the DUT hands a word over.
// -----------------------------------------------------------------------------
module tb_fifo_pack_reader;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;
    localparam int DW    = WIDTH * RATIO;

    logic          clk = 1'b0;
    logic          i_reset;
    logic          i_empty;
    logic          o_re;
    logic [7:0]    i_din;
    logic          i_flush;
    logic [DW-1:0] o_data;
    logic [3:0]    o_keep;
    logic          o_last;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    keep;
        logic          last;
    } word_t;

    typedef struct {
        int            n;
        logic [3:0][7:0] b;
        logic          flush;
        logic [DW-1:0] d;
        logic [3:0]    k;
        logic          l;
    } vec_t;

    word_t      sb[$];
    vec_t       vecs[$];
    logic [7:0] fifo_q[$];
    int         pushes   = 0;
    int         pops     = 0;
    int         checks   = 0;
    int         errors   = 0;
    int         re_count = 0;

    always #5 clk = ~clk;

    fifo_pack_reader #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .I_CLK   (clk),
        .I_RESET (i_reset),
        .I_EMPTY (i_empty),
        .O_RE    (o_re),
        .I_DIN   (i_din),
        .I_FLUSH (i_flush),
        .O_DATA  (o_data),
        .O_KEEP  (o_keep),
        .O_LAST  (o_last),
        .O_VALID (o_valid),
        .I_READY (i_ready),
        .O_BUSY  (o_busy)
    );

    assign i_empty = (pushes == pops);

    // Behavioural FIFO read port: data registered on an accepted read.
    always @(posedge clk) begin
        if (i_reset) begin
            fifo_q.delete();
            pops  <= pushes;
            i_din <= 8'h00;
        end else if (o_re && (fifo_q.size() > 0)) begin
            i_din <= fifo_q.pop_front();
            pops  <= pops + 1;
        end
    end

    // Output monitor: read-on-empty guard, read counter, scoreboard compare.
    always @(negedge clk) begin
        word_t e;
        if (!i_reset) begin
            if (o_re) re_count++;
            if (i_empty) begin
                checks++;
                if (o_re) begin
                    errors++;
                    $display("FAIL re_on_empty: O_RE=1 while I_EMPTY=1 at %0t", $time);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h keep=%b last=%b, none expected",
                             o_data, o_keep, o_last);
                end else begin
                    e = sb.pop_front();
                    if (o_data !== e.data || o_keep !== e.keep || o_last !== e.last) begin
                        errors++;
                        $display("FAIL word_out: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                                 o_data, o_keep, o_last, e.data, e.keep, e.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        pushes++;
    endtask

    task automatic sb_add(input logic [DW-1:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        sb.push_back(w);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (sb.size() != 0 && n < budget);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words still pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_fifo_empty(input int budget, input string name);
        int n = 0;
        while (pushes != pops && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(pushes - pops), 32'd0);
    endtask

    task automatic add_vec(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic fl,
                           input logic [DW-1:0] d, input logic [3:0] k, input logic l);
        vec_t v;
        v.n = n;
        v.b = {b3, b2, b1, b0};
        v.flush = fl;
        v.d = d;
        v.k = k;
        v.l = l;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // {bytes, flush-after-capture, expected data/keep/last}
        add_vec(4, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 32'h44332211, 4'b1111, 1'b0);
        add_vec(4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 32'hEFBEADDE, 4'b1111, 1'b0);
        add_vec(2, 8'hA1, 8'hA2, 8'h00, 8'h00, 1'b1, 32'h0000A2A1, 4'b0011, 1'b1);
        add_vec(1, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0000005A, 4'b0001, 1'b1);
        add_vec(3, 8'h01, 8'h02, 8'h03, 8'h00, 1'b1, 32'h00030201, 4'b0111, 1'b1);
        add_vec(4, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 32'h00FF00FF, 4'b1111, 1'b0);
        add_vec(4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h00000000, 4'b1111, 1'b0);

        i_reset = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();

        // Reset values; a non-empty FIFO must not produce a read while in reset.
        push(8'h99);
        #1;
        check("rst_re",    32'(o_re),    32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  o_data,       32'd0);
        check("rst_keep",  32'(o_keep),  32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        tick();
        i_reset = 1'b0;
        tick();

        // Basic pack with latency: the first read is taken at edge k, the word
        // is registered at edge k+RATIO+1, i.e. seen RATIO+2 samples later.
        sb_add(32'h44332211, 4'b1111, 1'b0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        check("basic_first_re", 32'(o_re), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            if (!o_valid) n++;
        end while (!o_valid && n < 20);
        check("basic_latency", 32'(n), 32'(RATIO + 2));
        wait_drain(20, "basic_drain");

        // Table-driven words, with and without a flush after capture.
        foreach (vecs[i]) begin
            sb_add(vecs[i].d, vecs[i].k, vecs[i].l);
            for (int j = 0; j < vecs[i].n; j++) push(vecs[i].b[j]);
            if (vecs[i].flush) begin
                wait_fifo_empty(20, "vec_fifo_read");
                tick();
                tick();
                i_flush = 1'b1;
                tick();
                i_flush = 1'b0;
                check("vec_busy_set", 32'(o_busy), 32'd1);
                tick();
                check("vec_busy_clr", 32'(o_busy), 32'd0);
            end
            wait_drain(30, "vec_drain");
        end

        // Flush in the same cycle as the third read: in-flight byte is included,
        // the fourth byte stays in the FIFO until the flush completes.
        sb_add(32'h00B3B2B1, 4'b0111, 1'b1);
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        tick();
        tick();
        check("inflight_re3", 32'(o_re), 32'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("inflight_no_re_a", 32'(o_re),   32'd0);
        check("inflight_busy",    32'(o_busy), 32'd1);
        tick();
        check("inflight_no_re_b", 32'(o_re),   32'd0);
        wait_drain(20, "inflight_drain");
        sb_add(32'hC3C2C1B4, 4'b1111, 1'b0);
        push(8'hC1); push(8'hC2); push(8'hC3);
        wait_drain(30, "inflight_tail");

        // Backpressure: 12 bytes, output stalled for 20 cycles.
        i_ready = 1'b0;
        base = re_count;
        for (int j = 0; j < 12; j++) push(8'(8'h40 + j));
        sb_add(32'h43424140, 4'b1111, 1'b0);
        sb_add(32'h47464544, 4'b1111, 1'b0);
        sb_add(32'h4B4A4948, 4'b1111, 1'b0);
        repeat (8) tick();
        repeat (20) begin
            tick();
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_data",  o_data,       32'h43424140);
            check("bp_keep",  32'(o_keep),  32'hF);
        end
        check("bp_reads", 32'(re_count - base), 32'd8);
        i_ready = 1'b1;
        wait_drain(60, "bp_drain");
        check("bp_all_read", 32'(pushes - pops), 32'd0);

        // Empty flush: one busy cycle, no word; empty FIFO: no reads.
        base = re_count;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        check("eflush_busy_set", 32'(o_busy), 32'd1);
        tick();
        check("eflush_busy_clr", 32'(o_busy), 32'd0);
        repeat (8) begin
            tick();
            check("eflush_no_valid", 32'(o_valid), 32'd0);
        end
        check("empty_no_reads", 32'(re_count - base), 32'd0);

        // Reset mid-word with a word held in the output register.
        i_ready = 1'b0;
        for (int j = 0; j < 6; j++) push(8'(8'h50 + j));
        repeat (14) tick();
        check("midrst_pre_valid", 32'(o_valid), 32'd1);
        i_reset = 1'b1;
        tick();
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_data",  o_data,       32'd0);
        check("midrst_keep",  32'(o_keep),  32'd0);
        check("midrst_last",  32'(o_last),  32'd0);
        check("midrst_busy",  32'(o_busy),  32'd0);
        check("midrst_re",    32'(o_re),    32'd0);
        i_reset = 1'b0;
        i_ready = 1'b1;
        tick();
        sb_add(32'h63626160, 4'b1111, 1'b0);
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        wait_drain(30, "midrst_clean_word");

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
